// File: rtl/seg7_scan_display.sv
// ---------------------------------------------------------------------------
// seg7_scan_display
//
// Multiplexed seven-segment display controller. A value captured on a load
// strobe is shown either in hex or in unsigned decimal. Decimal values go
// through a sequential shift-add-3 (double dabble) converter, one bit per
// clock. The digits are scanned one anode at a time. Optional features are
// leading-zero blanking, per-digit decimal points and a dash pattern for
// decimal values that do not fit in the available digits.
//
// Ports:
//   clock     system clock, everything on the rising edge
//   reset     synchronous, active-high
//   value     DATA_W-bit unsigned number to display
//   load      one-cycle strobe; captures value, mode and blank_lz
//   mode      0 = hex, 1 = unsigned decimal
//   blank_lz  1 = blank leading zero digits
//   dp_mask   per-digit decimal point enables, used live (not captured)
//   busy      decimal conversion in progress
//   ovf       last decimal load needed more than DIGITS digits
//   an        anode enables, active-low, one-hot-low
//   seg       segments, active-low, bit0 = a ... bit6 = g
//   dp        decimal point, active-low
// ---------------------------------------------------------------------------
module seg7_scan_display #(
  parameter int DIGITS   = 4,
  parameter int DATA_W   = 14,
  parameter int SCAN_DIV = 50000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] value,
  input  logic              load,
  input  logic              mode,
  input  logic              blank_lz,
  input  logic [DIGITS-1:0] dp_mask,
  output logic              busy,
  output logic              ovf,
  output logic [DIGITS-1:0] an,
  output logic [6:0]        seg,
  output logic              dp
);

  localparam int PRE_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  // ceil(DATA_W/3) decimal digits always hold a DATA_W-bit number because
  // each decimal digit covers more than 3 bits.
  localparam int BCD_D  = (DATA_W + 2) / 3;
  // The converter is at least DIGITS wide so the digit register can always
  // be loaded straight from its low nibbles.
  localparam int EXT_D  = (BCD_D > DIGITS) ? BCD_D : DIGITS;
  localparam int BCD_W  = 4 * EXT_D;
  localparam int HEX_W  = 4 * DIGITS;
  localparam int VEXT_W = (DATA_W > HEX_W) ? DATA_W : HEX_W;
  localparam int CNT_W  = $clog2(DATA_W + 1);

  typedef enum logic {
    ST_IDLE,
    ST_CONV
  } state_t;

  // Scan state
  logic [PRE_W-1:0]  presc_q;
  logic [IDX_W-1:0]  idx_q;
  logic              wrap;

  // Conversion / capture state
  state_t            state_q;
  logic [DATA_W-1:0] bin_q;
  logic [BCD_W-1:0]  bcd_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [HEX_W-1:0]  digits_q;
  logic              ovf_q;
  logic              busy_q;
  logic              mode_q;
  logic              blank_q;

  // Registered pin drivers
  logic [DIGITS-1:0] an_q;
  logic [6:0]        seg_q;
  logic              dp_q;

  // Next-state values for the pin drivers
  logic [DIGITS-1:0] an_d;
  logic [6:0]        seg_d;
  logic              dp_d;

  // Conversion datapath
  logic [BCD_W-1:0]  bcdAdj;
  logic [BCD_W-1:0]  bcdStep;
  logic [DATA_W-1:0] binStep;
  logic              stepOvf;
  logic [VEXT_W-1:0] valueExt;
  logic [HEX_W-1:0]  hexDigits;

  // Display selection helpers
  logic [DIGITS-1:0] upperZero;
  logic              zeroRun;
  logic [3:0]        curDigit;
  logic              curBlank;
  logic              curDp;

  // Hex and blank/dash segment patterns, active-low gfedcba.
  function automatic logic [6:0] decodeHex(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // The prescaler holds each anode for SCAN_DIV cycles; the index moves on
  // only when the prescaler wraps.
  assign wrap = (presc_q == PRE_W'(SCAN_DIV - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      presc_q <= '0;
      idx_q   <= '0;
    end else if (wrap) begin
      presc_q <= '0;
      idx_q   <= (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end else begin
      presc_q <= presc_q + PRE_W'(1);
    end
  end

  // One double-dabble step: every BCD nibble of 5 or more gets 3 added, then
  // the whole {bcd, bin} pair shifts left by one so the next binary bit
  // enters the BCD side. Any nonzero nibble above the displayable digits
  // means the value does not fit.
  always_comb begin
    bcdAdj = bcd_q;
    for (int k = 0; k < EXT_D; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) begin
        bcdAdj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
      end
    end
    bcdStep = {bcdAdj[BCD_W-2:0], bin_q[DATA_W-1]};
    binStep = {bin_q[DATA_W-2:0], 1'b0};
    stepOvf = 1'b0;
    for (int k = 0; k < EXT_D; k++) begin
      if (k >= DIGITS) begin
        stepOvf = stepOvf | (bcdStep[4*k +: 4] != 4'd0);
      end
    end
  end

  // Hex digits are plain nibbles of the value, zero-extended to fill every
  // digit.
  assign valueExt  = VEXT_W'(value);
  assign hexDigits = valueExt[HEX_W-1:0];

  // Capture and conversion FSM. A hex load updates the digits at the load
  // edge. A decimal load starts DATA_W conversion steps with busy high; the
  // digits and ovf are written together on the final step, so an abort by
  // reset never leaves a partial result. Loads are ignored while converting.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      bin_q    <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      digits_q <= '0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      mode_q   <= 1'b0;
      blank_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (load) begin
            mode_q  <= mode;
            blank_q <= blank_lz;
            if (!mode) begin
              digits_q <= hexDigits;
              ovf_q    <= 1'b0;
            end else begin
              bin_q   <= value;
              bcd_q   <= '0;
              cnt_q   <= '0;
              busy_q  <= 1'b1;
              state_q <= ST_CONV;
            end
          end
        end
        ST_CONV: begin
          bin_q <= binStep;
          bcd_q <= bcdStep;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            digits_q <= bcdStep[HEX_W-1:0];
            ovf_q    <= stepOvf;
            busy_q   <= 1'b0;
            state_q  <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // upperZero[i] is set when digit i and every digit above it are zero,
  // which is exactly the leading-zero blanking condition for digit i.
  always_comb begin
    upperZero = '0;
    zeroRun   = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zeroRun      = zeroRun & (digits_q[4*i +: 4] == 4'd0);
      upperZero[i] = zeroRun;
    end
  end

  // Pick the digit, blanking state and decimal point for the current scan
  // index. Digit 0 is never blanked; the dash pattern overrides blanking.
  always_comb begin
    curDigit = 4'd0;
    curBlank = 1'b0;
    curDp    = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        curDigit = digits_q[4*i +: 4];
        curBlank = (i > 0) && upperZero[i];
        curDp    = dp_mask[i];
      end
    end
    an_d = ~(DIGITS'(1) << idx_q);
    dp_d = ~curDp;
    if (ovf_q && mode_q) begin
      seg_d = 7'h3F;
    end else if (blank_q && curBlank) begin
      seg_d = 7'h7F;
    end else begin
      seg_d = decodeHex(curDigit);
    end
  end

  // All pin drivers are registered, so they follow the scan index and the
  // digit register one cycle later. Reset turns the display fully dark.
  always_ff @(posedge clock) begin
    if (reset) begin
      an_q  <= '1;
      seg_q <= 7'h7F;
      dp_q  <= 1'b1;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
    end
  end

  assign an   = an_q;
  assign seg  = seg_q;
  assign dp   = dp_q;
  assign busy = busy_q;
  assign ovf  = ovf_q;

endmodule
